// File: rtl/dw_pw_loop_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dw_pw_loop_scheduler
// Purpose  : Loop-nest sequencer for the pointwise-conv stage. For every
//            output-channel group it walks every pixel, and for each pixel
//            every input channel. It issues feature/weight reads, drives
//            accumulator clear/enable, and hands each finished pixel to
//            write-back through a valid/ready handshake.
// Ports    : clk, rst (async, active-high)
//            start, input_size (S), input_channel (IC), output_channel (OC)
//            out_ready             - write-back accepts current pixel
//            busy                  - not IDLE
//            fmap_rd_en/fmap_addr  - feature read, addr = ic*S*S + pix
//            wgt_rd_en/wgt_addr    - weight read,  addr = og*IC + ic
//            acc_en/acc_clr        - accumulate / clear-then-accumulate
//            wb_valid/wb_addr      - pixel result, addr = og*S*S + pix
//            oc_group              - current output-channel group
//            done                  - one-cycle completion pulse
//            stall_cycles          - write-back stall counter
// Options  : DW_PW_SCHED_PERF_CNT_EN enables the stall_cycles counter;
//            otherwise stall_cycles is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dw_pw_loop_scheduler #(
    parameter int PE_NUM = 8,
    parameter int ADDR_W = 24,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        input_size,
    input  logic [7:0]        input_channel,
    input  logic [7:0]        output_channel,
    input  logic              out_ready,
    output logic              busy,
    output logic              fmap_rd_en,
    output logic [ADDR_W-1:0] fmap_addr,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_addr,
    output logic              acc_en,
    output logic              acc_clr,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [7:0]        oc_group,
    output logic              done,
    output logic [31:0]       stall_cycles
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RUN   = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_WB    = 3'd3;
    localparam logic [2:0] c_FIN   = 3'd4;
    localparam logic [1:0] c_DRAIN_LAST = 2'(RD_LAT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [15:0]       r_ss;
    logic [7:0]        r_ic_n;
    logic [7:0]        r_ng;
    logic [7:0]        r_ic;
    logic [15:0]       r_pix;
    logic [7:0]        r_og;
    logic [1:0]        r_drain;
    logic              r_empty;
    logic [ADDR_W-1:0] r_fbase;
    logic [ADDR_W-1:0] r_wbase;
    logic [ADDR_W-1:0] r_obase;
    logic [RD_LAT-1:0] r_acc_pipe;
    logic [RD_LAT-1:0] r_clr_pipe;

    logic [15:0] w_ss;
    logic [8:0]  w_oc_round;
    logic [7:0]  w_ng;
    logic        w_cfg_zero;
    logic        w_ic_last;
    logic        w_pix_last;
    logic        w_og_last;
    logic        w_drain_last;
    logic        w_rd;

    assign w_ss         = 16'(input_size) * 16'(input_size);
    assign w_oc_round   = {1'b0, output_channel} + 9'(PE_NUM - 1);
    assign w_ng         = 8'(w_oc_round / 9'(PE_NUM));
    assign w_cfg_zero   = (input_size == 8'd0) || (input_channel == 8'd0) ||
                          (output_channel == 8'd0);
    assign w_ic_last    = (r_ic == r_ic_n - 8'd1);
    assign w_pix_last   = (r_pix == r_ss - 16'd1);
    assign w_og_last    = (r_og == r_ng - 8'd1);
    assign w_drain_last = (r_drain == c_DRAIN_LAST);
    assign w_rd         = (r_state == c_RUN);

    // Address outputs are base registers plus the running inner index; the
    // bases advance by S*S or IC, so no multiplier sits on the address path.
    assign fmap_addr = r_fbase + ADDR_W'(r_pix);
    assign wgt_addr  = r_wbase + ADDR_W'(r_ic);
    assign wb_addr   = r_obase + ADDR_W'(r_pix);
    assign oc_group  = r_og;
    assign acc_en    = r_acc_pipe[RD_LAT-1];
    assign acc_clr   = r_clr_pipe[RD_LAT-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = w_cfg_zero ? c_FIN : c_RUN;
            c_RUN:   if (w_ic_last) w_state_nxt = c_DRAIN;
            c_DRAIN: if (w_drain_last) w_state_nxt = c_WB;
            c_WB:    if (out_ready)
                         w_state_nxt = (w_pix_last && w_og_last) ? c_FIN : c_RUN;
            // An empty job spends one extra FIN cycle before done so that
            // done lands two cycles after the start.
            c_FIN:   if (!r_empty) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (r_state != c_IDLE);
        fmap_rd_en = w_rd;
        wgt_rd_en  = w_rd;
        wb_valid   = (r_state == c_WB);
        done       = (r_state == c_FIN) && !r_empty;
    end

    // Loop counters and address bases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss    <= '0;
            r_ic_n  <= '0;
            r_ng    <= '0;
            r_ic    <= '0;
            r_pix   <= '0;
            r_og    <= '0;
            r_drain <= '0;
            r_empty <= 1'b0;
            r_fbase <= '0;
            r_wbase <= '0;
            r_obase <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_ss    <= w_ss;
                        r_ic_n  <= input_channel;
                        r_ng    <= w_ng;
                        r_empty <= w_cfg_zero;
                        r_ic    <= '0;
                        r_pix   <= '0;
                        r_og    <= '0;
                        r_drain <= '0;
                        r_fbase <= '0;
                        r_wbase <= '0;
                        r_obase <= '0;
                    end
                end
                c_RUN: begin
                    if (w_ic_last) begin
                        r_ic    <= '0;
                        r_fbase <= '0;
                    end else begin
                        r_ic    <= r_ic + 8'd1;
                        r_fbase <= r_fbase + ADDR_W'(r_ss);
                    end
                end
                c_DRAIN: begin
                    r_drain <= w_drain_last ? 2'd0 : r_drain + 2'd1;
                end
                c_WB: begin
                    if (out_ready) begin
                        if (w_pix_last) begin
                            r_pix <= '0;
                            // Keep og on the last group so oc_group does not
                            // show an out-of-range value during FIN.
                            if (!w_og_last) begin
                                r_og    <= r_og + 8'd1;
                                r_wbase <= r_wbase + ADDR_W'(r_ic_n);
                                r_obase <= r_obase + ADDR_W'(r_ss);
                            end
                        end else begin
                            r_pix <= r_pix + 16'd1;
                        end
                    end
                end
                c_FIN: begin
                    r_empty <= 1'b0;
                end
                default: begin
                    r_empty <= 1'b0;
                end
            endcase
        end
    end

    // Read-return alignment: acc strobes trail the read strobe by RD_LAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_pipe <= '0;
            r_clr_pipe <= '0;
        end else begin
            r_acc_pipe <= RD_LAT'({r_acc_pipe, w_rd});
            r_clr_pipe <= RD_LAT'({r_clr_pipe, (w_rd && (r_ic == 8'd0))});
        end
    end

`ifdef DW_PW_SCHED_PERF_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((r_state == c_IDLE) && start) begin
            r_stall <= '0;
        end else if ((r_state == c_WB) && !out_ready && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/dw_pw_loop_scheduler.md
Name: dw_pw_loop_scheduler

Overview:
- Loop-nest sequencer for the pointwise-conv stage of each conv layer. Started by the layer FSM when pointwise is enabled.
- Per output-channel group it walks every pixel and every input channel. It issues feature/weight reads, drives accumulator clear/enable, and hands each finished pixel to the write-back path through a valid/ready handshake.
- Emits a one-cycle done pulse, which the layer FSM consumes as point_done.

Parameters:
- PE_NUM, 8: output channels computed in parallel; one weight word holds PE_NUM weights.
- ADDR_W, 24: width of all address outputs.
- RD_LAT, 1: feature/weight buffer read latency in cycles (legal range 1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  start pulse; sampled only in IDLE.
- input_size  in  8  feature map side S (pixels per channel = S*S).
- input_channel  in  8  IC.
- output_channel  in  8  OC.
- out_ready  in  1  write-back path accepts the current pixel.
- busy  out  1  high in any state other than IDLE.
- fmap_rd_en  out  1  feature buffer read strobe.
- fmap_addr  out  ADDR_W  ic*S*S + pix.
- wgt_rd_en  out  1  weight buffer read strobe; identical timing to fmap_rd_en.
- wgt_addr  out  ADDR_W  og*IC + ic.
- acc_en  out  1  accumulate the returned data.
- acc_clr  out  1  clear accumulator before adding; coincides with the first acc_en of a pixel.
- wb_valid  out  1  accumulator result ready.
- wb_addr  out  ADDR_W  og*S*S + pix.
- oc_group  out  8  current output-channel group og.
- done  out  1  one-cycle completion pulse.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset: every output is 0, state is IDLE, all counters are 0. Reset asserted mid-operation aborts immediately with no done pulse.
- States: IDLE, RUN, DRAIN, WB, FIN.
- IDLE:
  - start=1 latches S, IC, OC and computes NG = ceil(OC/PE_NUM).
  - If S, IC or OC is 0, go to FIN (no reads). Otherwise go to RUN with og=pix=ic=0.
- RUN (one read per cycle):
  - fmap_rd_en = wgt_rd_en = 1; ic increments each cycle.
  - After the cycle with ic=IC-1, go to DRAIN.
- DRAIN: lasts exactly RD_LAT cycles, then go to WB.
- Accumulator timing: acc_en is fmap_rd_en delayed by RD_LAT cycles. acc_clr is the delayed "ic==0" flag.
- WB:
  - wb_valid = 1, with wb_addr and oc_group held stable until out_ready = 1.
  - The handshake completes on the cycle where wb_valid and out_ready are both 1.
  - On handshake: ic=0 and pix increments. If pix wraps past S*S-1, then pix=0 and og increments. If og reaches NG, go to FIN; else go to RUN.
- FIN: done = 1 for one cycle, then IDLE.
- Per-pixel cost: IC + RD_LAT + 1 cycles when out_ready stays high.
- start while busy is ignored. Config inputs changing while busy have no effect.
- Address arithmetic:
  - Incremental adders only, no multipliers. fmap_addr base steps by S*S per ic; wgt base steps by IC per og.
  - S*S is computed once at start (16 bits).
  - All addresses are truncated modulo 2^ADDR_W.
- OC not a multiple of PE_NUM: the last group still walks the full loop. Masking unused PE lanes is the datapath's responsibility.
- out_ready held 0: the scheduler waits in WB indefinitely, with no reads and no acc_en.

Optional Feature:
- Macro: DW_PW_SCHED_PERF_CNT_EN.
- Enabled: stall_cycles counts cycles with wb_valid=1 and out_ready=0. It clears on the start that launches a run, saturates at 2^32-1, and holds its value after done.
- Disabled: stall_cycles is tied to 0 and no counter logic is synthesised; the port list is unchanged.

Test Plan:
- S=2, IC=3, OC=8, PE_NUM=8, RD_LAT=1, out_ready=1, start at cycle 0:
  - Reads occur in cycles 1-3, 6-8, 11-13 and 16-18.
  - fmap_addr in cycles 1-3 is 0, 4, 8. wb_valid occurs in cycles 5, 10, 15 and 20, with wb_addr 0..3.
  - done is high in cycle 21 only.
- S=2, IC=2, OC=20, PE_NUM=8:
  - NG=3; oc_group steps 0, 1, 2.
  - wgt_addr for og=2 is 4, 5. The last wb_addr is 11. Exactly 12 write-backs occur.
- out_ready held 0 for 7 cycles at the first WB:
  - wb_valid and wb_addr stay stable and no reads occur.
  - With the macro enabled, stall_cycles=7 at done.
- IC=0 (or S=0) with start: no rd_en and no wb_valid; done pulses 2 cycles after start.
- rst asserted during RUN of pixel 1: all outputs are 0 asynchronously and done never pulses. A subsequent start runs the full sequence correctly from pixel 0.
- start re-pulsed while busy: no effect on the sequence or on the final done timing.
